// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM state type and the misalignment rule for the RV32I MEM stage.
package mem_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

    // Stores size from SB/SH, loads from funct3; unknown load funct3 behaves as a word.
    function automatic logic misaligned(input logic st, input logic sb, input logic sh,
                                        input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        if (st) begin
            if (sb) begin
                mis = 1'b0;
            end else if (sh) begin
                mis = off[0];
            end else begin
                mis = (off != 2'b00);
            end
        end else begin
            case (f3)
                F3_LB, F3_LBU: mis = 1'b0;
                F3_LH, F3_LHU: mis = off[0];
                default:       mis = (off != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane logic: store data replication and byte enables, load byte/half extraction and extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic        sb,
    input  logic        sh,
    input  logic        we,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store lanes: replicate the datum so any lane the enables pick holds it.
    always_comb begin
        wdata = st_data;
        be    = 4'b1111;
        if (we) begin
            if (sb) begin
                wdata = {4{st_data[7:0]}};
                be    = 4'b0001 << st_off;
            end else if (sh) begin
                wdata = {2{st_data[15:0]}};
                be    = st_off[1] ? 4'b1100 : 4'b0011;
            end else begin
                wdata = st_data;
                be    = 4'b1111;
            end
        end else begin
            wdata = st_data;
            be    = 4'b1111;
        end
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        ld_byte_s = 8'h00;
        case (ld_off)
            2'd0:    ld_byte_s = rdata[7:0];
            2'd1:    ld_byte_s = rdata[15:8];
            2'd2:    ld_byte_s = rdata[23:16];
            2'd3:    ld_byte_s = rdata[31:24];
            default: ld_byte_s = rdata[7:0];
        endcase
        ld_half_s = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LW:   ld_data = rdata;
            F3_LBU:  ld_data = {24'h000000, ld_byte_s};
            F3_LHU:  ld_data = {16'h0000, ld_half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: issues data-memory accesses over valid/ready, stalls while they are outstanding,
// and owns the MEM/WB register.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int Width = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             RegWEn_MEM,
    input  logic [1:0]       WBSel_MEM,
    input  logic             st_en_MEM,
    input  logic             SB_MEM,
    input  logic             SH_MEM,
    input  logic [Width-1:0] pc_MEM,
    input  logic [Width-1:0] alu_MEM,
    input  logic [Width-1:0] DataB_MEM,
    input  logic [Width-1:0] inst_MEM,
    output logic             stall_o,
    output logic             dmem_req_valid_o,
    input  logic             dmem_req_ready_i,
    output logic             dmem_we_o,
    output logic [Width-1:0] dmem_addr_o,
    output logic [Width-1:0] dmem_wdata_o,
    output logic [3:0]       dmem_be_o,
    input  logic             dmem_rsp_valid_i,
    input  logic [Width-1:0] dmem_rdata_i,
    output logic             RegWEn_WB,
    output logic [1:0]       WBSel_WB,
    output logic [Width-1:0] pc_WB,
    output logic [Width-1:0] alu_WB,
    output logic [Width-1:0] ld_data_WB,
    output logic [Width-1:0] inst_WB,
    output logic             misalign_WB
);

    lsu_state_e       state_r, next_state_s;
    logic [Width-1:0] addr_r, wdata_r;
    logic [3:0]       be_r;
    logic             we_r;
    logic [2:0]       f3_r;
    logic [1:0]       off_r;

    logic             memop_s, misalign_s;
    logic             req_valid_s, req_we_s, stall_s;
    logic [Width-1:0] req_addr_s, req_wdata_s;
    logic [3:0]       req_be_s;
    logic             latch_s, capture_s, mis_cap_s, ld_done_s;
    logic [Width-1:0] al_wdata_s, al_ld_s;
    logic [3:0]       al_be_s;

    lsu_align u_align (
        .sb        (SB_MEM),
        .sh        (SH_MEM),
        .we        (st_en_MEM),
        .st_off    (alu_MEM[1:0]),
        .st_data   (DataB_MEM),
        .ld_funct3 (f3_r),
        .ld_off    (off_r),
        .rdata     (dmem_rdata_i),
        .wdata     (al_wdata_s),
        .be        (al_be_s),
        .ld_data   (al_ld_s)
    );

    // Classify the instruction currently in MEM.
    always_comb begin
        memop_s    = st_en_MEM | ((WBSel_MEM == WB_MEM) & RegWEn_MEM);
        misalign_s = misaligned(st_en_MEM, SB_MEM, SH_MEM, inst_MEM[14:12], alu_MEM[1:0]);
    end

    // Access sequencing: bus request, stall and MEM/WB capture decisions.
    always_comb begin
        next_state_s = state_r;
        req_valid_s  = 1'b0;
        req_we_s     = we_r;
        req_addr_s   = addr_r;
        req_wdata_s  = wdata_r;
        req_be_s     = be_r;
        stall_s      = 1'b0;
        latch_s      = 1'b0;
        capture_s    = 1'b0;
        mis_cap_s    = 1'b0;
        ld_done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (memop_s && !misalign_s) begin
                    req_valid_s = 1'b1;
                    req_we_s    = st_en_MEM;
                    req_addr_s  = {alu_MEM[Width-1:2], 2'b00};
                    req_wdata_s = al_wdata_s;
                    req_be_s    = al_be_s;
                    latch_s     = 1'b1;
                    if (dmem_req_ready_i) begin
                        if (st_en_MEM) begin
                            capture_s = 1'b1;
                        end else begin
                            stall_s      = 1'b1;
                            next_state_s = RSP;
                        end
                    end else begin
                        stall_s      = 1'b1;
                        next_state_s = REQ;
                    end
                end else if (memop_s) begin
                    capture_s = 1'b1;
                    mis_cap_s = 1'b1;
                end else begin
                    capture_s = 1'b1;
                end
            end
            REQ: begin
                req_valid_s = 1'b1;
                if (dmem_req_ready_i) begin
                    if (we_r) begin
                        capture_s    = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        stall_s      = 1'b1;
                        next_state_s = RSP;
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            RSP: begin
                if (dmem_rsp_valid_i) begin
                    capture_s    = 1'b1;
                    ld_done_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign stall_o          = stall_s;
    assign dmem_req_valid_o = req_valid_s;
    assign dmem_we_o        = req_we_s;
    assign dmem_addr_o      = req_addr_s;
    assign dmem_wdata_o     = req_wdata_s;
    assign dmem_be_o        = req_be_s;

    // FSM state, latched request fields and the MEM/WB register; non-capture cycles insert a bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            addr_r      <= {Width{1'b0}};
            wdata_r     <= {Width{1'b0}};
            be_r        <= 4'b0000;
            we_r        <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            RegWEn_WB   <= 1'b0;
            WBSel_WB    <= 2'b00;
            pc_WB       <= {Width{1'b0}};
            alu_WB      <= {Width{1'b0}};
            ld_data_WB  <= {Width{1'b0}};
            inst_WB     <= {Width{1'b0}};
            misalign_WB <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                addr_r  <= {alu_MEM[Width-1:2], 2'b00};
                wdata_r <= al_wdata_s;
                be_r    <= al_be_s;
                we_r    <= st_en_MEM;
                f3_r    <= inst_MEM[14:12];
                off_r   <= alu_MEM[1:0];
            end
            if (capture_s) begin
                RegWEn_WB   <= RegWEn_MEM & ~mis_cap_s;
                WBSel_WB    <= WBSel_MEM;
                pc_WB       <= pc_MEM;
                alu_WB      <= alu_MEM;
                ld_data_WB  <= ld_done_s ? al_ld_s : {Width{1'b0}};
                inst_WB     <= inst_MEM;
                misalign_WB <= mis_cap_s;
            end else begin
                RegWEn_WB   <= 1'b0;
                WBSel_WB    <= WB_ALU;
                pc_WB       <= {Width{1'b0}};
                alu_WB      <= {Width{1'b0}};
                ld_data_WB  <= {Width{1'b0}};
                inst_WB     <= NOP_INST;
                misalign_WB <= 1'b0;
            end
        end
    end

endmodule
